// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the asynchronous FIFO pointer logic.
//   SIDE_WR / SIDE_RD : side encoding used by fifo_ptr_gen's SIDE parameter
//   MAX_PTR_W         : widest pointer supported (ADDR_W up to 16, plus wrap bit)
//   gray_enc()        : binary-to-Gray encoder; narrower pointers are
//                       zero-extended into it and the result truncated back
package fifo_pkg;

  localparam int SIDE_WR   = 0;
  localparam int SIDE_RD   = 1;
  localparam int MAX_PTR_W = 17;

  function automatic logic [MAX_PTR_W-1:0] gray_enc(input logic [MAX_PTR_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin
// Parametrised Gray-to-binary decoder.  Each binary bit is the XOR of the
// Gray bits from the MSB down to its own position (prefix XOR).
// Ports:
//   gray  in  W  Gray-coded value
//   bin   out W  binary equivalent
module gray_to_bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // One reduction per bit keeps the decode free of combinational self-reads.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/fifo_ptr_gen.sv
// fifo_ptr_gen
// Pointer generator for one side of an asynchronous FIFO.  Holds the binary
// pointer and its registered Gray copy, accepts increments when the status
// flag is clear, and derives the registered flag (full on the write side,
// empty on the read side) and occupancy level from the synchronised Gray
// pointer of the opposite domain.
// Optional feature: define FIFO_ALMOST_EN to add the registered almost flag.
// Parameters:
//   ADDR_W    RAM address width (depth 2^ADDR_W), 1..16
//   SIDE      SIDE_WR (flag = full) or SIDE_RD (flag = empty)
//   ALMOST_TH almost-flag distance from the boundary, 0..2^ADDR_W
// Ports:
//   clk             in   domain clock, rising edge
//   rst_n           in   synchronous active-low reset
//   inc             in   increment request (push / pop)
//   other_gray_sync in   opposite-domain Gray pointer, already synchronised
//   xfer            out  increment accepted this cycle (combinational)
//   addr            out  RAM address, low ADDR_W bits of ptr_bin
//   ptr_bin         out  registered binary pointer
//   ptr_gray        out  registered Gray pointer (to the opposite synchroniser)
//   flag            out  registered full / empty
//   level           out  registered occupancy, 0..2^ADDR_W
//   almost          out  registered almost-full / almost-empty (FIFO_ALMOST_EN)
module fifo_ptr_gen
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int SIDE      = SIDE_WR,
  parameter int ALMOST_TH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic [ADDR_W:0]   other_gray_sync,
  output logic              xfer,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   ptr_bin,
  output logic [ADDR_W:0]   ptr_gray,
  output logic              flag,
  output logic [ADDR_W:0]   level
`ifdef FIFO_ALMOST_EN
  ,
  output logic              almost
`endif
);

  localparam int PW = ADDR_W + 1;

  // Full means "same position, one lap ahead": in Gray code that is the
  // opposite pointer with its two MSBs inverted (both bits when PW = 2).
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] bin_nxt;
  logic [PW-1:0] gray_nxt;
  logic [PW-1:0] other_bin;
  logic [PW-1:0] level_nxt;
  logic          flag_nxt;

  gray_to_bin #(.W(PW)) u_other_dec (
    .gray (other_gray_sync),
    .bin  (other_bin)
  );

  // Reset gates xfer so an inc during reset never reaches the RAM.
  assign xfer = rst_n & inc & ~flag;
  assign addr = ptr_bin[ADDR_W-1:0];

  // Next pointer, its Gray form, and the status it implies against the
  // opposite pointer as presented this cycle.
  always_comb begin
    bin_nxt  = ptr_bin + PW'(xfer);
    gray_nxt = PW'(gray_enc(MAX_PTR_W'(bin_nxt)));
    if (SIDE == SIDE_WR) begin
      level_nxt = bin_nxt - other_bin;
      flag_nxt  = (gray_nxt == (other_gray_sync ^ FULL_MASK));
    end else begin
      level_nxt = other_bin - bin_nxt;
      flag_nxt  = (gray_nxt == other_gray_sync);
    end
  end

  // Pointer and status registers; the read side comes out of reset empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_bin  <= '0;
      ptr_gray <= '0;
      level    <= '0;
      flag     <= (SIDE == SIDE_RD);
    end else begin
      ptr_bin  <= bin_nxt;
      ptr_gray <= gray_nxt;
      level    <= level_nxt;
      flag     <= flag_nxt;
    end
  end

`ifdef FIFO_ALMOST_EN
  logic almost_nxt;

  // Almost flag compares the next level against the threshold distance
  // from the relevant boundary.
  always_comb begin
    if (SIDE == SIDE_WR) begin
      almost_nxt = (int'(level_nxt) >= ((1 << ADDR_W) - ALMOST_TH));
    end else begin
      almost_nxt = (int'(level_nxt) <= ALMOST_TH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      almost <= (SIDE == SIDE_RD);
    end else begin
      almost <= almost_nxt;
    end
  end
`endif

endmodule

// File: doc/fifo_ptr_gen.md
# fifo_ptr_gen

Parametrised pointer generator for one side (write or read) of the asynchronous FIFO. Keeps an (ADDR_W+1)-bit binary pointer and its registered Gray encoding, accepts increments under a valid/ready-style handshake, and produces the FIFO status flag (full or empty) and the occupancy level. It compares its own pointer against the opposite-domain Gray pointer, which arrives already synchronised. One instance sits in each clock domain of the FIFO; the Gray output feeds the opposite domain's synchroniser.

## Interface
- ADDR_W, 4, RAM address width; FIFO depth = 2^ADDR_W; pointers are ADDR_W+1 bits; legal range 1..16
- SIDE, 0, 0 = write side (flag = full), 1 = read side (flag = empty)
- ALMOST_TH, 2, almost-flag distance from the full or empty boundary; legal range 0..2^ADDR_W
- clk  in  1  domain clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- inc  in  1  increment request (push on write side, pop on read side)
- other_gray_sync  in  ADDR_W+1  opposite-domain Gray pointer, already synchronised into clk
- xfer  out  1  increment accepted this cycle; xfer = inc & ~flag (combinational)
- addr  out  ADDR_W  RAM address; equals ptr_bin[ADDR_W-1:0]
- ptr_bin  out  ADDR_W+1  registered binary pointer
- ptr_gray  out  ADDR_W+1  registered Gray pointer; always equals ptr_bin ^ (ptr_bin >> 1)
- flag  out  1  registered full (SIDE=0) or empty (SIDE=1)
- level  out  ADDR_W+1  registered occupancy as seen by this side, range 0..2^ADDR_W
- almost  out  1  registered almost-full or almost-empty; present only with FIFO_ALMOST_EN

## Operation
- Accept condition: inc & ~flag. An accept advances the pointer: bin_nxt = ptr_bin + 1, modulo 2^(ADDR_W+1). With no accept, bin_nxt = ptr_bin.
- Gray encoding: gray_nxt = bin_nxt ^ (bin_nxt >> 1). Register the result. Never expose a combinational Gray value.
- Full (SIDE=0): gray_nxt == {~other_gray_sync[ADDR_W:ADDR_W-1], other_gray_sync[ADDR_W-2:0]}. When ADDR_W=1, both bits are inverted.
- Empty (SIDE=1): gray_nxt == other_gray_sync.
- Occupancy: other_bin = Gray-to-binary conversion of other_gray_sync.
  - SIDE=0: level_nxt = bin_nxt - other_bin, modulo 2^(ADDR_W+1).
  - SIDE=1: level_nxt = other_bin - bin_nxt, modulo 2^(ADDR_W+1).
- Write side flag is set exactly when level = 2^ADDR_W. Read side flag is set exactly when level = 0.
- Inc while the flag is set: ignored. xfer=0 and all registers hold.
- Wrap-around: after 2^(ADDR_W+1) accepts, ptr_bin returns to 0. Each accept changes exactly one ptr_gray bit, including across the wrap (ADDR_W=4: 11111 -> 00000 in binary, 10000 -> 00000 in Gray).
- Reset values:
  - ptr_bin = 0, ptr_gray = 0, addr = 0, level = 0.
  - SIDE=0: flag = 0, almost = 0.
  - SIDE=1: flag = 1, almost = 1.
- While rst_n = 0, xfer is forced to 0.

## Timing
- xfer has zero latency: same cycle as inc.
- ptr_bin, ptr_gray and addr update on the clock edge that ends the accept cycle.
- flag, level and almost are registered. They reflect bin_nxt against other_gray_sync as sampled at that same edge. Self-caused transitions therefore have 1-cycle latency: a push into the last free slot asserts full on the following cycle.
- A change on other_gray_sync shows in flag and level one cycle after it is presented. The synchroniser delay upstream is outside this block.
- An accept and an opposite-pointer change in the same cycle are both folded into the single registered update.
- Reset mid-operation: the first edge with rst_n = 0 loads all reset values. Any inc in that cycle is discarded. Operation resumes on the first edge with rst_n = 1.

## Configuration
- FIFO_ALMOST_EN defined: the almost port and its register exist.
  - SIDE=0: almost = (level_nxt >= 2^ADDR_W - ALMOST_TH).
  - SIDE=1: almost = (level_nxt <= ALMOST_TH).
- FIFO_ALMOST_EN undefined: no almost port, no register, no comparator. All other behaviour is identical.

## Structure
- Shared package fifo_pkg holds:
  - side encoding constants SIDE_WR = 0 and SIDE_RD = 1;
  - a parametrised Gray-encode function.
- One sub-module: gray_to_bin. It is a parametrised Gray-to-binary decoder (prefix XOR from the MSB down) used for other_bin.

## Test plan
- Reset, ADDR_W=4, SIDE=0: hold rst_n=0 for 2 cycles -> ptr_bin=0, ptr_gray=0, flag=0, level=0. SIDE=1 instance -> flag=1.
- Write side, other_gray_sync=0, inc held for 16 cycles -> level counts 1..16, flag=1 in the cycle after the 16th accept, 17th inc gives xfer=0 with ptr_bin held at 16.
- Wrap: 32 accepts with the opposite pointer tracking -> ptr_bin returns to 0, and the Hamming distance between consecutive ptr_gray values is 1 every step, including 31->0.
- Read side, other_gray_sync stepped to Gray(3), then 3 pops -> flag deasserts 1 cycle later, level reads 3,2,1,0, flag=1 after the third pop.
- Simultaneous: write side at level 15 pushes in the same cycle that other_gray_sync advances by 1 -> level stays 15, flag stays 0.
- Reset at level 9 mid-stream with inc=1 -> next cycle all reset values, xfer=0 during reset. With FIFO_ALMOST_EN and ALMOST_TH=2, the write side asserts almost at level 14.
